// File: rtl/cpu_defs.sv
// Shared definitions for the fetch stage: FSM encoding, reset vector and PC step.
package cpu_defs;
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Signed word offset from an imm16 field, as a byte displacement.
  function automatic logic [31:0] branch_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction
endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target generation and redirect priority. Holding cases return the current pc.
module next_pc_sel
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] npc,
  output logic        advance,
  output logic        misalign_fault
);

  always_comb begin
    npc            = pc;
    advance        = 1'b0;
    misalign_fault = 1'b0;
    if (halt_req || stall) begin
      npc = pc;
    end else if (jump_reg) begin
      // A misaligned register target is never loaded; the fault parks the core.
      if (reg_target[1:0] != 2'b00) begin
        misalign_fault = 1'b1;
      end else begin
        npc     = reg_target;
        advance = 1'b1;
      end
    end else if (jump) begin
      npc     = {pc_plus4[31:28], jump_target, 2'b00};
      advance = 1'b1;
    end else if (branch_taken) begin
      npc     = pc_plus4 + branch_disp(branch_offset);
      advance = 1'b1;
    end else begin
      npc     = pc_plus4;
      advance = 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter register and boot/run/halt sequencing for instruction fetch.
//  state | meaning
//  BOOT  | out of reset, pc = reset vector, fetch not yet valid
//  RUN   | fetching; pc advances or redirects each cycle unless held
//  HALT  | halt instruction or misaligned jump_reg; frozen until reset
module pc_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_target,
  input  logic             jump_reg,
  input  logic [31:0]      reg_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             misaligned,
  output logic [CNT_W-1:0] inst_count
);

  state_t     state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] npc;
  logic        advance;
  logic        misalign_fault;
  logic [CNT_W-1:0] cnt_q;
  logic        mis_q;
  logic        run;

  assign run = (state_q == ST_RUN);

  next_pc_sel u_sel (
    .pc             (pc_q),
    .pc_plus4       (pc_plus4),
    .halt_req       (halt_req),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_target    (jump_target),
    .jump_reg       (jump_reg),
    .reg_target     (reg_target),
    .npc            (npc),
    .advance        (advance),
    .misalign_fault (misalign_fault)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt_req || misalign_fault) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (run && advance) begin
        pc_q  <= npc;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (run && misalign_fault) mis_q <= 1'b1;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_INC;
  assign fetch_valid = run;
  assign halted      = (state_q == ST_HALT);
  assign misaligned  = mis_q;
  assign inst_count  = cnt_q;

endmodule
